// File: rtl/nios_system_pio_irq_pkg.sv
// Shared constants and helpers for the Avalon-MM bidirectional PIO with interrupt.
package nios_pio_pkg;

  // Register word addresses on the slave port
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  // Edge-capture selection encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Clears every bit at or above 'width' so readdata never leaks unused bits
  function automatic logic [31:0] zero_extend(input logic [31:0] value, input int width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) result[i] = value[i];
    end
    return result;
  endfunction

endpackage

// File: rtl/nios_system_pio_irq_if.sv
// Avalon-MM slave bus bundle for the PIO: 3-bit word address, 32-bit data, read latency 1.
interface nios_system_pio_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_system_pio_irq_sync_edge.sv
// Input synchroniser chain, one-cycle history flop and per-bit edge detector.
module pio_sync_edge
  import nios_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_evt
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_in;

  // Shift the asynchronous pins through the synchroniser and remember last synced value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_in <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_in <= sync_in;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Select which transition of the synchronised input counts as an event
  always_comb begin
    edge_evt = sync_in & ~prev_in;
    case (EDGE_TYPE)
      EDGE_FALL: edge_evt = ~sync_in & prev_in;
      EDGE_ANY:  edge_evt = sync_in ^ prev_in;
      default:   edge_evt = sync_in & ~prev_in;
    endcase
  end

endmodule

// File: rtl/nios_system_pio_irq.sv
// Bidirectional PIO with per-bit direction, atomic set/clear, edge capture and masked IRQ.
module nios_system_pio_irq
  import nios_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          EDGE_TYPE   = EDGE_RISE,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_OUT   = 32'h0,
  parameter logic [31:0] RESET_DIR   = 32'h0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  nios_system_pio_irq_if.slave        bus,
  input  logic [WIDTH-1:0]            in_port,
  output logic [WIDTH-1:0]            out_port,
  output logic [WIDTH-1:0]            oe,
  output logic                        irq
);

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_cap_next;
  logic [WIDTH-1:0] clear_bits;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_evt;
  logic [31:0]      read_word;
  logic [31:0]      readdata_q;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign rd_en = bus.chipselect & ~bus.read_n;
  assign wd    = bus.writedata[WIDTH-1:0];

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .sync_in  (sync_in),
    .edge_evt (edge_evt)
  );

  // Next edge-capture value: W1C applied first, then new events OR in so a set wins
  always_comb begin
    clear_bits = '0;
    if (wr_en && bus.address == ADDR_EDGE) clear_bits = wd;
    edge_cap_next = (edge_cap & ~clear_bits) | edge_evt;
  end

  // Writable registers and the sticky edge-capture register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT[WIDTH-1:0];
      dir      <= RESET_DIR[WIDTH-1:0];
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_en) begin
        case (bus.address)
          ADDR_DATA:   data_out <= wd;
          ADDR_DIR:    dir      <= wd;
          ADDR_MASK:   irq_mask <= wd;
          ADDR_OUTSET: data_out <= data_out | wd;
          ADDR_OUTCLR: data_out <= data_out & ~wd;
          default:     ;
        endcase
      end
      edge_cap <= edge_cap_next;
    end
  end

  // Read mux over current register values, so a same-cycle write is not visible yet
  always_comb begin
    read_word = '0;
    case (bus.address)
      ADDR_DATA: read_word = 32'(sync_in);
      ADDR_DIR:  read_word = 32'(dir);
      ADDR_MASK: read_word = 32'(irq_mask);
      ADDR_EDGE: read_word = 32'(edge_cap);
      default:   read_word = '0;
    endcase
  end

  // Readdata holds the last read result until the next read strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (rd_en) begin
      readdata_q <= zero_extend(read_word, WIDTH);
    end
  end

  // Registered interrupt: any captured edge on an enabled bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_cap & irq_mask);
    end
  end

  assign bus.readdata = readdata_q;
  assign out_port     = data_out;
  assign oe           = dir;

endmodule

// File: tb/tb_nios_system_pio_irq.sv
// Directed self-checking bench: rising-edge instance plus an any-edge instance with non-zero reset values.
module tb_nios_system_pio_irq;
  import nios_pio_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in0;
  logic [7:0] in1;
  wire  [7:0] out0;
  wire  [7:0] oe0;
  wire  [7:0] out1;
  wire  [7:0] oe1;
  wire        irq0;
  wire        irq1;
  int         checks = 0;
  int         passed = 0;
  logic [31:0] rdata;

  nios_system_pio_irq_if bus0();
  nios_system_pio_irq_if bus1();

  nios_system_pio_irq #(
    .WIDTH(8), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2),
    .RESET_OUT(32'h0), .RESET_DIR(32'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave),
    .in_port(in0), .out_port(out0), .oe(oe0), .irq(irq0)
  );

  nios_system_pio_irq #(
    .WIDTH(8), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2),
    .RESET_OUT(32'h5A), .RESET_DIR(32'h3C)
  ) dut_any (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave),
    .in_port(in1), .out_port(out1), .oe(oe1), .irq(irq1)
  );

  always #5 clk = ~clk;

  // Drive one bus; rd/wr are active-high here and inverted onto the strobes
  task automatic drive_bus(input int which, input logic [2:0] a, input logic cs,
                           input logic rd, input logic wr, input logic [31:0] d);
    if (which == 0) begin
      bus0.address = a; bus0.chipselect = cs; bus0.read_n = ~rd;
      bus0.write_n = ~wr; bus0.writedata = d;
    end else begin
      bus1.address = a; bus1.chipselect = cs; bus1.read_n = ~rd;
      bus1.write_n = ~wr; bus1.writedata = d;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int which, input logic [2:0] a, input logic [31:0] d);
    drive_bus(which, a, 1'b1, 1'b0, 1'b1, d);
    tick(1);
    drive_bus(which, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic bus_read(input int which, input logic [2:0] a, output logic [31:0] q);
    drive_bus(which, a, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(1);
    drive_bus(which, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    q = (which == 0) ? bus0.readdata : bus1.readdata;
  endtask

  task automatic bus_rw(input int which, input logic [2:0] a, input logic [31:0] d,
                        output logic [31:0] q);
    drive_bus(which, a, 1'b1, 1'b1, 1'b1, d);
    tick(1);
    drive_bus(which, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    q = (which == 0) ? bus0.readdata : bus1.readdata;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic read_check(input int which, input logic [2:0] a, input logic [31:0] exp,
                            input string tag);
    logic [31:0] q;
    bus_read(which, a, q);
    check_output(tag, q, exp);
  endtask

  // Directed sequence
  initial begin
    drive_bus(0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive_bus(1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    in0 = 8'h00;
    in1 = 8'h00;
    reset_n = 1'b0;
    tick(3);
    check_output("rst_out_port", 32'(out0), 32'h00);
    check_output("rst_oe", 32'(oe0), 32'h00);
    check_output("rst_irq", 32'(irq0), 32'h0);
    check_output("rst_readdata", bus0.readdata, 32'h0);
    check_output("rst_any_out_port", 32'(out1), 32'h5A);
    check_output("rst_any_oe", 32'(oe1), 32'h3C);
    reset_n = 1'b1;
    tick(1);

    // Register map after reset
    for (int a = 0; a < 8; a++) read_check(0, 3'(a), 32'h0, $sformatf("rst_read_addr%0d", a));
    read_check(1, ADDR_DIR, 32'h3C, "rst_any_dir");

    // Output writes, atomic set and clear
    bus_write(0, ADDR_DATA, 32'h1234_56A5);
    check_output("data_write_upper_ignored", 32'(out0), 32'hA5);
    bus_write(0, ADDR_OUTSET, 32'h0F);
    check_output("outset", 32'(out0), 32'hAF);
    bus_write(0, ADDR_OUTCLR, 32'h81);
    check_output("outclr", 32'(out0), 32'h2E);
    read_check(0, ADDR_DATA, 32'h00, "data_reads_sync_in");
    read_check(0, ADDR_OUTSET, 32'h00, "outset_reads_zero");
    bus_write(0, 3'd6, 32'hFF);
    check_output("reserved_write_ignored", 32'(out0), 32'h2E);
    read_check(0, 3'd6, 32'h0, "reserved_read_zero");
    bus_write(0, ADDR_DIR, 32'hFFFF_FFF0);
    check_output("dir_oe", 32'(oe0), 32'hF0);
    read_check(0, ADDR_DIR, 32'hF0, "dir_read");
    bus_rw(0, ADDR_DIR, 32'h0F, rdata);
    check_output("rw_pre_write_value", rdata, 32'hF0);
    read_check(0, ADDR_DIR, 32'h0F, "rw_post_write_value");
    bus_write(1, ADDR_OUTCLR, 32'hFF);
    check_output("any_outclr", 32'(out1), 32'h00);

    // Rising edge on bit3: capture lands exactly three clocks after the pin change
    in0 = 8'h08;
    tick(2);
    read_check(0, ADDR_EDGE, 32'h00, "edge_not_before_3clk");
    read_check(0, ADDR_EDGE, 32'h08, "edge_at_3clk");
    read_check(0, ADDR_DATA, 32'h08, "data_sync_in");
    check_output("irq_masked_off", 32'(irq0), 32'h0);
    bus_write(0, ADDR_MASK, 32'h08);
    check_output("irq_registered_delay", 32'(irq0), 32'h0);
    tick(1);
    check_output("irq_assert", 32'(irq0), 32'h1);
    bus_write(0, ADDR_EDGE, 32'h08);
    check_output("irq_still_high_after_w1c", 32'(irq0), 32'h1);
    tick(1);
    check_output("irq_deassert", 32'(irq0), 32'h0);
    read_check(0, ADDR_EDGE, 32'h00, "edge_cleared");

    // Event on bit2 in the same cycle as its W1C: set wins
    in0 = 8'h0C;
    tick(2);
    bus_write(0, ADDR_EDGE, 32'h04);
    read_check(0, ADDR_EDGE, 32'h04, "set_wins_over_w1c");
    check_output("irq_unmasked_bit", 32'(irq0), 32'h0);
    bus_write(0, ADDR_EDGE, 32'h04);
    read_check(0, ADDR_EDGE, 32'h00, "w1c_bit2");

    // Falling edge is not captured by the rising-edge instance
    in0 = 8'h04;
    tick(4);
    read_check(0, ADDR_EDGE, 32'h00, "rise_ignores_fall");

    // Any-edge instance: both transitions of a pulse are captured
    in1 = 8'h01;
    tick(5);
    bus_write(1, ADDR_EDGE, 32'hFF);
    read_check(1, ADDR_EDGE, 32'h00, "any_cleared");
    in1 = 8'h00;
    tick(4);
    read_check(1, ADDR_EDGE, 32'h01, "any_fall_captured");
    bus_write(1, ADDR_EDGE, 32'h01);
    read_check(1, ADDR_EDGE, 32'h00, "any_w1c");
    in1 = 8'h01;
    tick(4);
    read_check(1, ADDR_EDGE, 32'h01, "any_rise_captured");
    in1 = 8'h21;
    #3 in1 = 8'h01;
    #4 in1 = 8'h41;
    #4 in1 = 8'h01;
    tick(5);
    read_check(1, ADDR_EDGE, 32'h41, "glitch_isolated");

    // Load edge_cap=0xFF with irq active, then assert reset between clock edges
    in0 = 8'h00;
    tick(4);
    in0 = 8'hFF;
    tick(4);
    bus_write(0, ADDR_MASK, 32'hFF);
    tick(1);
    check_output("irq_all_bits", 32'(irq0), 32'h1);
    read_check(0, ADDR_EDGE, 32'hFF, "edge_all_bits");
    @(negedge clk);
    #1 reset_n = 1'b0;
    in0 = 8'h00;
    #1;
    check_output("async_rst_out_port", 32'(out0), 32'h00);
    check_output("async_rst_oe", 32'(oe0), 32'h00);
    check_output("async_rst_irq", 32'(irq0), 32'h0);
    check_output("async_rst_readdata", bus0.readdata, 32'h0);
    check_output("async_rst_any_out_port", 32'(out1), 32'h5A);
    tick(2);
    reset_n = 1'b1;
    tick(4);
    read_check(0, ADDR_EDGE, 32'h00, "post_rst_edge");
    read_check(0, ADDR_MASK, 32'h00, "post_rst_mask");
    read_check(0, ADDR_DIR, 32'h00, "post_rst_dir");
    check_output("post_rst_irq", 32'(irq0), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Guard against a run that never reaches the summary
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
